// File: rtl/dual_rail_tx_arbiter.sv
// Round-robin arbiter driving one dual-rail link from NUM_REQ synchronous requesters.
// Tokens are two-phase (transition) or four-phase (return-to-zero), completed on a synced ack.
module dual_rail_tx_arbiter #(
   parameter string       ENC         = "TP",
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = 1023
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*WIDTH-1:0]     data,
   output logic [NUM_REQ-1:0]           gnt,
   output logic [2*WIDTH-1:0]           out,
   input  logic                         ack,
   output logic                         busy,
   output logic [$clog2(NUM_REQ)-1:0]   grant_id,
   output logic                         timeout_err
);

   localparam int unsigned IDW = $clog2(NUM_REQ);
   localparam int unsigned CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit          IS_TP = (ENC == "TP");
   localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_REQ - 1);
   localparam logic [CW-1:0]  CNT_MAX  = CW'(TIMEOUT);
   localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

   if (!(ENC == "TP" || ENC == "FP")) begin : g_bad_enc
      $fatal(1, "dual_rail_tx_arbiter: ENC must be TP or FP");
   end
   if (NUM_REQ < 2) begin : g_bad_num_req
      $fatal(1, "dual_rail_tx_arbiter: NUM_REQ must be >= 2");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $fatal(1, "dual_rail_tx_arbiter: SYNC_STAGES must be >= 2");
   end

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StWaitHi,
      StWaitLo
   } state_e;

   state_e                 state_q;
   logic [SYNC_STAGES-1:0] ack_sync_q;
   logic                   ack_phase_q;
   logic [IDW-1:0]         ptr_q;
   logic [NUM_REQ-1:0]     gnt_q;
   logic [2*WIDTH-1:0]     out_q;
   logic                   busy_q;
   logic [IDW-1:0]         grant_id_q;
   logic                   timeout_err_q;
   logic [CW-1:0]          wait_cnt_q;

   logic                   ack_s;
   logic                   found;
   logic [IDW-1:0]         pick;
   int unsigned            scan_idx;
   logic [WIDTH-1:0]       word;
   logic [2*WIDTH-1:0]     tok;
   logic                   wait_done;

   assign ack_s = ack_sync_q[SYNC_STAGES-1];

   // Scan from the pointer so the last winner ends up with the lowest priority.
   always_comb begin
      found    = 1'b0;
      pick     = '0;
      scan_idx = 0;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         scan_idx = (32'(ptr_q) + j) % NUM_REQ;
         if (!found && req[scan_idx]) begin
            found = 1'b1;
            pick  = scan_idx[IDW-1:0];
         end
      end
   end

   always_comb begin
      word = data[pick*WIDTH +: WIDTH];
      tok  = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         tok[2*i +: 2] = word[i] ? 2'b10 : 2'b01;
      end
   end

   always_comb begin
      wait_done = 1'b0;
      unique case (state_q)
         StWait:   wait_done = (ack_s != ack_phase_q);
         StWaitHi: wait_done = ack_s;
         StWaitLo: wait_done = !ack_s;
         default:  wait_done = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         ack_sync_q    <= '0;
         ack_phase_q   <= 1'b0;
         ptr_q         <= '0;
         gnt_q         <= '0;
         out_q         <= '0;
         busy_q        <= 1'b0;
         grant_id_q    <= '0;
         timeout_err_q <= 1'b0;
         wait_cnt_q    <= '0;
      end else begin
         ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack};
         gnt_q      <= '0;

         unique case (state_q)
            StIdle: begin
               if (found) begin
                  gnt_q[pick] <= 1'b1;
                  grant_id_q  <= pick;
                  ptr_q       <= (pick == LAST_ID) ? '0 : pick + 1'b1;
                  out_q       <= IS_TP ? (out_q ^ tok) : tok;
                  busy_q      <= 1'b1;
                  wait_cnt_q  <= '0;
                  state_q     <= IS_TP ? StWait : StWaitHi;
               end
            end
            StWait: begin
               if (wait_done) begin
                  ack_phase_q <= ~ack_phase_q;
                  busy_q      <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            StWaitHi: begin
               if (wait_done) begin
                  out_q   <= '0;
                  state_q <= StWaitLo;
               end
            end
            StWaitLo: begin
               if (wait_done) begin
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase

         // Counter restarts on every state change; the token stays on the link after a timeout.
         if (TIMEOUT != 0 && state_q != StIdle) begin
            if (wait_done) begin
               wait_cnt_q <= '0;
            end else begin
               if (wait_cnt_q != CNT_MAX) begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
               if (wait_cnt_q == CNT_LAST) begin
                  timeout_err_q <= 1'b1;
               end
            end
         end
      end
   end

   assign gnt         = gnt_q;
   assign out         = out_q;
   assign busy        = busy_q;
   assign grant_id    = grant_id_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_dual_rail_tx_arbiter.sv
// Directed bench for dual_rail_tx_arbiter: one two-phase and one four-phase instance,
// grant expectations queued at stimulus time and checked by per-link monitors.
module tb_dual_rail_tx_arbiter;

   localparam int W  = 8;
   localparam int N  = 4;
   localparam int SS = 2;
   localparam int TO = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_t, ack_t, busy_t, err_t;
   logic [N-1:0]     req_t, gnt_t;
   logic [N*W-1:0]   data_t;
   logic [2*W-1:0]   out_t;
   logic [1:0]       gid_t;

   logic             rst_f, ack_f, busy_f, err_f;
   logic [N-1:0]     req_f, gnt_f;
   logic [N*W-1:0]   data_f;
   logic [2*W-1:0]   out_f;
   logic [1:0]       gid_f;

   dual_rail_tx_arbiter #(
      .ENC("TP"), .WIDTH(W), .NUM_REQ(N), .SYNC_STAGES(SS), .TIMEOUT(TO)
   ) u_tp (
      .clk(clk), .rst(rst_t), .req(req_t), .data(data_t), .gnt(gnt_t), .out(out_t),
      .ack(ack_t), .busy(busy_t), .grant_id(gid_t), .timeout_err(err_t)
   );

   dual_rail_tx_arbiter #(
      .ENC("FP"), .WIDTH(W), .NUM_REQ(N), .SYNC_STAGES(SS), .TIMEOUT(TO)
   ) u_fp (
      .clk(clk), .rst(rst_f), .req(req_f), .data(data_f), .gnt(gnt_f), .out(out_f),
      .ack(ack_f), .busy(busy_f), .grant_id(gid_f), .timeout_err(err_f)
   );

   typedef struct {
      int         id;
      logic [7:0] word;
   } exp_t;

   exp_t q_t[$];
   exp_t q_f[$];

   int pass_cnt  = 0;
   int check_cnt = 0;
   int fail_cnt  = 0;

   logic [2*W-1:0] prev_out_t = '0;

   function automatic logic [2*W-1:0] enc(input logic [W-1:0] w);
      logic [2*W-1:0] r;
      for (int i = 0; i < W; i++) r[2*i +: 2] = w[i] ? 2'b10 : 2'b01;
      return r;
   endfunction

   function automatic logic [W-1:0] dec(input logic [2*W-1:0] rails);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = rails[2*i+1];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt = check_cnt + 1;
      assert (obs === exp) pass_cnt = pass_cnt + 1;
      else begin
         fail_cnt = fail_cnt + 1;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(input bit fp, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         tick();
         if ((fp ? gnt_f : gnt_t) != '0) ok = 1'b1;
      end
   endtask

   task automatic wait_idle(input bit fp, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         tick();
         if ((fp ? busy_f : busy_t) == 1'b0) ok = 1'b1;
      end
   endtask

   // Two-phase monitor: the token is the rail difference against the previous link value.
   always @(negedge clk) begin
      exp_t e;
      if (gnt_t !== '0) begin
         if (q_t.size() == 0) begin
            chk("tp_unexpected_gnt", 32'(gnt_t), 32'd0);
         end else begin
            e = q_t.pop_front();
            chk("tp_gnt_id", 32'(gid_t), 32'(e.id));
            chk("tp_gnt_onehot", 32'(gnt_t), 32'(1) << e.id);
            chk("tp_token", 32'(out_t ^ prev_out_t), 32'(enc(e.word)));
         end
      end
      prev_out_t = out_t;
   end

   // Four-phase monitor: the token is the link value itself.
   always @(negedge clk) begin
      exp_t e;
      if (gnt_f !== '0) begin
         if (q_f.size() == 0) begin
            chk("fp_unexpected_gnt", 32'(gnt_f), 32'd0);
         end else begin
            e = q_f.pop_front();
            chk("fp_gnt_id", 32'(gid_f), 32'(e.id));
            chk("fp_gnt_onehot", 32'(gnt_f), 32'(1) << e.id);
            chk("fp_rails", 32'(out_f), 32'(enc(e.word)));
            chk("fp_decode", 32'(dec(out_f)), 32'(e.word));
         end
      end
   end

   initial begin
      bit             ok;
      logic [2*W-1:0] saved;
      logic [7:0]     dv [N];

      rst_t = 1'b1; ack_t = 1'b0; req_t = '0; data_t = '0;
      rst_f = 1'b1; ack_f = 1'b0; req_f = '0; data_f = '0;
      tick(); tick();
      chk("tp_rst_out", 32'(out_t), 32'd0);
      chk("tp_rst_gnt", 32'(gnt_t), 32'd0);
      chk("tp_rst_busy", 32'(busy_t), 32'd0);
      chk("tp_rst_gid", 32'(gid_t), 32'd0);
      chk("tp_rst_err", 32'(err_t), 32'd0);
      chk("fp_rst_out", 32'(out_f), 32'd0);
      chk("fp_rst_busy", 32'(busy_f), 32'd0);
      rst_t = 1'b0; rst_f = 1'b0;
      tick();

      // TP single token from requester 0.
      req_t = 4'b0001;
      data_t[0 +: 8] = 8'hA5;
      q_t.push_back('{0, 8'hA5});
      tick();
      chk("tp_latency_gnt", 32'(gnt_t), 32'h1);
      chk("tp_a5_out", 32'(out_t), 32'(enc(8'hA5)));
      chk("tp_busy_set", 32'(busy_t), 32'd1);
      req_t = '0;
      ack_t = 1'b1;
      tick();
      chk("tp_gnt_pulse", 32'(gnt_t), 32'd0);
      tick();
      chk("tp_busy_hold", 32'(busy_t), 32'd1);
      chk("tp_out_hold", 32'(out_t), 32'(enc(8'hA5)));
      tick();
      chk("tp_busy_fall", 32'(busy_t), 32'd0);

      // Round robin with all requesters held; receiver reset alongside the arbiter.
      rst_t = 1'b1; ack_t = 1'b0;
      tick();
      rst_t = 1'b0;
      dv[0] = 8'h0F; dv[1] = 8'hB1; dv[2] = 8'hC2; dv[3] = 8'hD3;
      for (int k = 0; k < N; k++) data_t[k*W +: W] = dv[k];
      for (int t = 0; t < 8; t++) q_t.push_back('{t % N, dv[t % N]});
      req_t = 4'hF;
      for (int t = 0; t < 8; t++) begin
         wait_gnt(1'b0, ok);
         chk("rr_gnt_seen", 32'(ok), 32'd1);
         tick();
         chk("rr_gnt_single", 32'(gnt_t), 32'd0);
         ack_t = ~ack_t;
         wait_idle(1'b0, ok);
         chk("rr_idle", 32'(ok), 32'd1);
      end
      req_t = '0;
      chk("rr_all_popped", 32'(q_t.size()), 32'd0);

      // A one-cycle req pulse during a wait is ignored; a held req wins next IDLE.
      req_t = 4'b0001;
      q_t.push_back('{0, dv[0]});
      wait_gnt(1'b0, ok);
      chk("wd_first_gnt", 32'(ok), 32'd1);
      req_t = 4'b1100;
      tick();
      req_t = 4'b1000;
      q_t.push_back('{3, dv[3]});
      ack_t = ~ack_t;
      wait_gnt(1'b0, ok);
      chk("wd_second_gnt", 32'(ok), 32'd1);
      chk("wd_skip_2", 32'(gid_t), 32'd3);
      req_t = '0;
      ack_t = ~ack_t;
      wait_idle(1'b0, ok);
      chk("wd_idle", 32'(ok), 32'd1);

      // Timeout: ack never answers.
      req_t = 4'b0010;
      q_t.push_back('{1, dv[1]});
      wait_gnt(1'b0, ok);
      chk("to_gnt", 32'(ok), 32'd1);
      req_t = '0;
      saved = out_t;
      repeat (TO - 1) tick();
      chk("to_not_yet", 32'(err_t), 32'd0);
      tick();
      chk("to_err_set", 32'(err_t), 32'd1);
      chk("to_out_held", 32'(out_t), 32'(saved));
      chk("to_busy", 32'(busy_t), 32'd1);
      repeat (3) tick();
      chk("to_sticky", 32'(err_t), 32'd1);
      rst_t = 1'b1; ack_t = 1'b0;
      tick();
      chk("to_rst_err", 32'(err_t), 32'd0);
      chk("to_rst_out", 32'(out_t), 32'd0);
      rst_t = 1'b0;
      chk("tp_all_popped", 32'(q_t.size()), 32'd0);

      // FP single token from requester 1.
      for (int k = 0; k < N; k++) data_f[k*W +: W] = dv[k];
      data_f[1*W +: W] = 8'h3C;
      req_f = 4'b0010;
      q_f.push_back('{1, 8'h3C});
      tick();
      chk("fp_latency_gnt", 32'(gnt_f), 32'h2);
      chk("fp_3c_out", 32'(out_f), 32'(enc(8'h3C)));
      req_f = '0;
      ack_f = 1'b1;
      tick(); tick();
      chk("fp_out_hold", 32'(out_f), 32'(enc(8'h3C)));
      tick();
      chk("fp_rtz", 32'(out_f), 32'd0);
      chk("fp_busy_lo", 32'(busy_f), 32'd1);
      ack_f = 1'b0;
      tick(); tick();
      chk("fp_busy_hold", 32'(busy_f), 32'd1);
      tick();
      chk("fp_idle", 32'(busy_f), 32'd0);

      // Reset while in WAIT_HI abandons the token and the pointer.
      req_f = 4'b0001;
      q_f.push_back('{0, dv[0]});
      wait_gnt(1'b1, ok);
      chk("fp_hi_gnt", 32'(ok), 32'd1);
      req_f = '0;
      tick();
      rst_f = 1'b1;
      tick();
      chk("fp_rst_mid_out", 32'(out_f), 32'd0);
      chk("fp_rst_mid_busy", 32'(busy_f), 32'd0);
      chk("fp_rst_mid_gnt", 32'(gnt_f), 32'd0);
      rst_f = 1'b0;
      req_f = 4'hF;
      q_f.push_back('{0, dv[0]});
      wait_gnt(1'b1, ok);
      chk("fp_ptr_gnt", 32'(ok), 32'd1);
      chk("fp_ptr_reset", 32'(gid_f), 32'd0);
      req_f = '0;
      ack_f = 1'b1;
      repeat (3) tick();
      chk("fp_rtz2", 32'(out_f), 32'd0);
      ack_f = 1'b0;
      wait_idle(1'b1, ok);
      chk("fp_idle2", 32'(ok), 32'd1);
      chk("fp_all_popped", 32'(q_f.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
